// File: rtl/branch_pkg.sv
// Shared constants for the branch redirect controller: branch_type bit positions,
// FSM state encoding and the default reset PC.
package branch_pkg;

    localparam int unsigned BT_PC4   = 0;
    localparam int unsigned BT_BTYPE = 1;
    localparam int unsigned BT_JAL   = 2;
    localparam int unsigned BT_JALR  = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect target: priority select jalr > jal > btype plus the target adder.
// misaligned_o flags a target whose low two bits are non-zero after the jalr bit0 clear.
module branch_target_gen
    import branch_pkg::*;
(
    input  logic [3:0]  branch_type_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic [31:0] jalr_sum;
    logic        unused_pc4;

    // pc4 only ever means "fall through", so it never contributes to the target.
    assign unused_pc4 = branch_type_i[BT_PC4];

    assign jalr_sum = rs1_i + imm_i;
    assign taken_o  = branch_type_i[BT_JALR] | branch_type_i[BT_JAL] | branch_type_i[BT_BTYPE];

    always_comb begin
        target_o = ex_pc_i + imm_i;
        if (branch_type_i[BT_JALR]) begin
            target_o = {jalr_sum[31:1], 1'b0};
        end
    end

    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: advances the PC on fetch accept, loads execute-stage redirects and
// holds flush_o for FLUSH_CYCLES cycles. Optional trap on misaligned targets: BRANCH_MISALIGN_TRAP_EN.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [3:0]  branch_type_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic        stall_i,
    input  logic        if_ready_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic        misalign_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q;
    logic        bt_taken;
    logic [31:0] tgt;
    logic        tgt_misaligned;
    logic [31:0] redirect_pc;
    logic        redirect_now;
    logic        accept;

    branch_target_gen u_target_gen (
        .branch_type_i (branch_type_i),
        .ex_pc_i       (ex_pc_i),
        .imm_i         (imm_i),
        .rs1_i         (rs1_i),
        .taken_o       (bt_taken),
        .target_o      (tgt),
        .misaligned_o  (tgt_misaligned)
    );

    // Branches are only sampled in RUN; during FLUSH the EX stage holds squashed work.
    assign redirect_now = (state_q == ST_RUN) & ex_valid_i & ~stall_i & bt_taken;
    assign accept       = pc_valid_o & if_ready_i & ~stall_i;

`ifdef BRANCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_now & tgt_misaligned;
        end
    end

    assign redirect_pc = tgt_misaligned ? TRAP_VEC : tgt;
    assign misalign_o  = misalign_q;
`else
    logic unused_trap;

    assign unused_trap = ^{TRAP_VEC, tgt[1:0], tgt_misaligned};
    assign redirect_pc = {tgt[31:2], 2'b00};
    assign misalign_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_now) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (accept) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    pc_d = pc_q + 32'd4;
                end
                // The counter runs even under stall so the flush length stays fixed.
                if (cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_now;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q != ST_IDLE);
    assign flush_o    = (state_q == ST_FLUSH);
    assign redirect_o = redirect_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch PC and flush window.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic [3:0]  branch_type_i;
    logic [31:0] ex_pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic        stall_i;
    logic        if_ready_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        redirect_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: remaining flush cycles counted down from FLUSH_CYCLES.
    logic [31:0] m_pc;
    bit          m_started;
    int          m_flush_left;
    bit          m_redirect;
    bit          m_misalign;

    branch_redirect_ctrl #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TRAP_VEC     (TRAP_VEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid_i),
        .branch_type_i (branch_type_i),
        .ex_pc_i       (ex_pc_i),
        .imm_i         (imm_i),
        .rs1_i         (rs1_i),
        .stall_i       (stall_i),
        .if_ready_i    (if_ready_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [31:0] t;
        bit          tk;
        if (!rst_n) begin
            m_pc = RESET_PC; m_started = 0; m_flush_left = 0; m_redirect = 0; m_misalign = 0;
            return;
        end
        if (!m_started) begin
            m_started = 1; m_redirect = 0; m_misalign = 0;
            return;
        end
        tk = (m_flush_left == 0) && ex_valid_i && !stall_i && (branch_type_i[3:1] != 3'b000);
        if (m_flush_left > 0) m_flush_left--;
        m_redirect = tk;
        m_misalign = 0;
        if (tk) begin
            if (branch_type_i[3]) t = (rs1_i + imm_i) & ~32'h1;
            else                  t = ex_pc_i + imm_i;
`ifdef BRANCH_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
                t = TRAP_VEC;
                m_misalign = 1;
            end
`else
            t = t & ~32'h3;
`endif
            m_pc = t;
            m_flush_left = FLUSH_CYCLES;
        end else if (!stall_i && if_ready_i) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 0; branch_type_i = 4'b0000; stall_i = 0; if_ready_i = 0;
        ex_pc_i = 0; imm_i = 0; rs1_i = 0;
    endtask

    task automatic settle();
        idle();
        repeat (FLUSH_CYCLES) tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        checks++;
        if ({pc_o, pc_valid_o, flush_o, redirect_o, misalign_o} !== {RESET_PC, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h v/f/r/m=%b%b%b%b required pc=%h 0000",
                     pc_o, pc_valid_o, flush_o, redirect_o, misalign_o, RESET_PC);
        end
    endtask

    task automatic test_fetch();
        rst_n = 1;
        if_ready_i = 1;
        checks++;
        if (pc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %b required 0", pc_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({pc_o, pc_valid_o} !== {32'(4 * i), 1'b1}) begin
                errors++;
                $display("FAIL seq_fetch_%0d: got pc=%h v=%b required pc=%h v=1",
                         i, pc_o, pc_valid_o, 32'(4 * i));
            end
        end
    endtask

    task automatic test_btype();
        int hi;
        ex_valid_i = 1; branch_type_i = 4'b0010; ex_pc_i = 32'h40; imm_i = 32'hFFFF_FFF0;
        if_ready_i = 1;
        tick();
        checks++;
        if ({pc_o, redirect_o, flush_o} !== {32'h30, 2'b11}) begin
            errors++;
            $display("FAIL btype_redirect: got pc=%h r=%b f=%b required pc=00000030 r=1 f=1",
                     pc_o, redirect_o, flush_o);
        end
        idle();
        hi = 1;
        repeat (4) begin
            tick();
            hi += int'(flush_o);
        end
        checks++;
        if (hi != FLUSH_CYCLES || pc_o !== 32'h30) begin
            errors++;
            $display("FAIL flush_length: got %0d cycles pc=%h required %0d cycles pc=00000030",
                     hi, pc_o, FLUSH_CYCLES);
        end
    endtask

    task automatic test_jalr_align();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef BRANCH_MISALIGN_TRAP_EN
        exp_pc = TRAP_VEC; exp_mis = 1;
`else
        exp_pc = 32'h1000; exp_mis = 0;
`endif
        ex_valid_i = 1; branch_type_i = 4'b1000; rs1_i = 32'h1001; imm_i = 32'h2;
        tick();
        checks++;
        if ({pc_o, redirect_o, misalign_o} !== {exp_pc, 1'b1, exp_mis}) begin
            errors++;
            $display("FAIL jalr_align: got pc=%h r=%b m=%b required pc=%h r=1 m=%b",
                     pc_o, redirect_o, misalign_o, exp_pc, exp_mis);
        end
        settle();
        ex_valid_i = 1; branch_type_i = 4'b0100; ex_pc_i = 32'h100; imm_i = 32'h2;
        tick();
        checks++;
        if ({pc_o, redirect_o, misalign_o} !== {32'h100, 1'b1, exp_mis}) begin
            errors++;
            $display("FAIL jal_align: got pc=%h r=%b m=%b required pc=00000100 r=1 m=%b",
                     pc_o, redirect_o, misalign_o, exp_mis);
        end
        settle();
    endtask

    task automatic test_priority();
        ex_valid_i = 1; branch_type_i = 4'b1110; rs1_i = 32'h2000; imm_i = 32'h10;
        ex_pc_i = 32'h500;
        tick();
        checks++;
        if ({pc_o, redirect_o} !== {32'h2010, 1'b1}) begin
            errors++;
            $display("FAIL priority_jalr: got pc=%h r=%b required pc=00002010 r=1",
                     pc_o, redirect_o);
        end
        settle();
        ex_valid_i = 1; branch_type_i = 4'b0001; if_ready_i = 1;
        tick();
        checks++;
        if ({pc_o, redirect_o, flush_o} !== {32'h2014, 2'b00}) begin
            errors++;
            $display("FAIL pc4_not_taken: got pc=%h r=%b f=%b required pc=00002014 r=0 f=0",
                     pc_o, redirect_o, flush_o);
        end
        idle();
    endtask

    task automatic test_flush_ignore();
        ex_valid_i = 1; branch_type_i = 4'b0010; ex_pc_i = 32'h800; imm_i = 32'h20;
        tick();
        checks++;
        if ({pc_o, redirect_o} !== {32'h820, 1'b1}) begin
            errors++;
            $display("FAIL first_redirect: got pc=%h r=%b required pc=00000820 r=1",
                     pc_o, redirect_o);
        end
        branch_type_i = 4'b0100; ex_pc_i = 32'h900; imm_i = 32'h40;
        tick();
        checks++;
        if ({pc_o, redirect_o, flush_o} !== {32'h820, 2'b01}) begin
            errors++;
            $display("FAIL flush_ignore_1: got pc=%h r=%b f=%b required pc=00000820 r=0 f=1",
                     pc_o, redirect_o, flush_o);
        end
        tick();
        checks++;
        if ({pc_o, redirect_o, flush_o} !== {32'h820, 2'b00}) begin
            errors++;
            $display("FAIL flush_ignore_2: got pc=%h r=%b f=%b required pc=00000820 r=0 f=0",
                     pc_o, redirect_o, flush_o);
        end
        idle();
    endtask

    task automatic test_stall();
        stall_i = 1; ex_valid_i = 1; branch_type_i = 4'b0100; ex_pc_i = 32'h900;
        imm_i = 32'h40; if_ready_i = 1;
        tick();
        checks++;
        if ({pc_o, pc_valid_o, redirect_o, flush_o} !== {32'h820, 3'b100}) begin
            errors++;
            $display("FAIL stall_hold: got pc=%h v=%b r=%b f=%b required pc=00000820 v=1 r=0 f=0",
                     pc_o, pc_valid_o, redirect_o, flush_o);
        end
        stall_i = 0; if_ready_i = 0;
        tick();
        checks++;
        if ({pc_o, redirect_o} !== {32'h940, 1'b1}) begin
            errors++;
            $display("FAIL unstall_redirect: got pc=%h r=%b required pc=00000940 r=1",
                     pc_o, redirect_o);
        end
        stall_i = 1;
        tick();
        checks++;
        if ({flush_o, pc_valid_o} !== 2'b11) begin
            errors++;
            $display("FAIL stall_flush_1: got f=%b v=%b required f=1 v=1", flush_o, pc_valid_o);
        end
        tick();
        checks++;
        if ({pc_o, redirect_o, flush_o} !== {32'h940, 2'b00}) begin
            errors++;
            $display("FAIL stall_flush_2: got pc=%h r=%b f=%b required pc=00000940 r=0 f=0",
                     pc_o, redirect_o, flush_o);
        end
        idle();
    endtask

    task automatic test_reset_mid_flush();
        ex_valid_i = 1; branch_type_i = 4'b0100; ex_pc_i = 32'h40; imm_i = 32'h80;
        tick();
        checks++;
        if ({pc_o, flush_o} !== {32'hC0, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_flush: got pc=%h f=%b required pc=000000c0 f=1",
                     pc_o, flush_o);
        end
        idle();
        rst_n = 0;
        tick();
        checks++;
        if ({pc_o, pc_valid_o, flush_o, redirect_o, misalign_o} !== {RESET_PC, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_flush: got pc=%h v/f/r/m=%b%b%b%b required pc=%h 0000",
                     pc_o, pc_valid_o, flush_o, redirect_o, misalign_o, RESET_PC);
        end
        rst_n = 1;
        tick();
        checks++;
        if ({pc_valid_o, flush_o} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_run: got v=%b f=%b required v=1 f=0", pc_valid_o, flush_o);
        end
    endtask

    task automatic test_random();
        logic [35:0] obs;
        logic [35:0] exp;
        idle();
        rst_n = 0;
        tick();
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            ex_valid_i    = ($urandom_range(0, 3) != 0);
            branch_type_i = 4'($urandom_range(0, 15));
            ex_pc_i       = $urandom();
            rs1_i         = $urandom();
            imm_i         = $urandom_range(0, 1) ? ($urandom_range(0, 63) - 32'd32) : $urandom();
            stall_i       = ($urandom_range(0, 4) == 0);
            if_ready_i    = ($urandom_range(0, 2) != 0);
            tick();
            obs = {pc_o, pc_valid_o, flush_o, redirect_o, misalign_o};
            exp = {m_pc, m_started, (m_flush_left > 0), m_redirect, m_misalign};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_%0d: got pc=%h v/f/r/m=%b required pc=%h v/f/r/m=%b",
                         i, obs[35:4], obs[3:0], exp[35:4], exp[3:0]);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_fetch();
        test_btype();
        test_jalr_align();
        test_priority();
        test_flush_ignore();
        test_stall();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Front-end PC sequencer and redirect controller.
- Owns the fetch PC register and advances it by 4 on each accepted fetch.
- Consumes the one-hot branch decision {jalr, jal, btype, pc4} from the execute-stage branch comparator and computes the redirect target.
- Loads the target into the PC and sequences a fixed-length flush of the IF/ID stages.
- Sits between the execute-stage branch logic and instruction fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush_o stays asserted after a redirect (legal range 1..7).
TRAP_VEC, 32'h0000_0100, target used when a misaligned redirect is trapped (optional feature only).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
ex_valid_i  in  1  execute stage holds a valid instruction this cycle.
branch_type_i  in  4  {jalr, jal, btype_taken, pc4} from the branch comparator.
ex_pc_i  in  32  PC of the execute-stage instruction.
imm_i  in  32  sign-extended immediate.
rs1_i  in  32  rs1 operand, used by jalr.
stall_i  in  1  pipeline stall; freezes PC and EX sampling.
if_ready_i  in  1  fetch accepts pc_o this cycle.
pc_o  out  32  current fetch PC.
pc_valid_o  out  1  pc_o is a valid fetch request.
flush_o  out  1  squash the IF/ID pipeline registers.
redirect_o  out  1  one-cycle pulse: PC was loaded from a redirect this cycle.
misalign_o  out  1  one-cycle pulse: trapped misaligned target (optional feature only; tied 0 otherwise).

Behaviour:
- Reset, synchronous on rst_n=0 at a clk edge:
  - pc_o=RESET_PC, pc_valid_o=0, flush_o=0, redirect_o=0, misalign_o=0.
  - state=IDLE, flush counter=0.
  - Reset mid-flush aborts the flush immediately.
- FSM states IDLE, RUN, FLUSH.
  - IDLE→RUN on the first cycle after reset release; pc_valid_o=1 from RUN onward.
- Taken = ex_valid_i & ~stall_i & (jalr|jal|btype_taken).
  - Priority if more than one taken bit is set: jalr > jal > btype.
  - pc4 alone, or all bits zero, means not taken.
- Target computation, 32-bit wrap-around arithmetic, carry discarded:
  - jal/btype: ex_pc_i+imm_i.
  - jalr: (rs1_i+imm_i) with bit0 cleared.
- RUN:
  - Taken at edge T: pc_o=target at T+1, redirect_o=1 for that cycle, flush_o=1, state→FLUSH, counter=FLUSH_CYCLES-1.
  - Redirect overrides a simultaneous fetch accept; no +4 is applied that cycle.
  - Else if pc_valid_o & if_ready_i & ~stall_i: pc_o += 4.
  - Else pc_o holds.
- FLUSH:
  - flush_o=1; ex_valid_i is ignored because EX holds squashed instructions.
  - pc_o advances on fetch accept as in RUN.
  - Counter decrements each cycle; at 0, next cycle flush_o=0 and state→RUN.
  - Total flush_o high time is exactly FLUSH_CYCLES cycles.
- stall_i=1:
  - pc_o holds and no redirect is sampled.
  - The flush counter still decrements.
  - pc_valid_o stays 1 in RUN/FLUSH.
- pc_valid_o stays 1 during the redirect cycle, so fetch may accept the target at T+1.

Optional Feature:
BRANCH_MISALIGN_TRAP_EN
- Defined:
  - A taken redirect with target[1:0]!=0 loads TRAP_VEC instead of the target.
  - misalign_o pulses 1 in the same cycle as redirect_o.
  - Flush proceeds normally.
- Undefined:
  - Target bits [1:0] are forced to 00 (jalr bit0 cleared as normal, bit1 also cleared).
  - misalign_o is tied 0.
  - No trap occurs.

Decomposition:
- Shared package branch_pkg:
  - Localparams for branch_type bit indices (BT_PC4=0, BT_BTYPE=1, BT_JAL=2, BT_JALR=3).
  - FSM state encoding (IDLE/RUN/FLUSH, 2 bits).
  - Default reset PC constant.
- One sub-module, branch_target_gen: combinational priority select plus adder producing target and misaligned flag. The FSM and PC register remain in the top.

Test Plan:
- Reset then if_ready_i=1 for 3 cycles → pc_o 0x0, 0x4, 0x8, 0xC.
  - pc_valid_o is 0 in the first cycle after reset release, then 1.
- RUN, ex_valid_i=1, branch_type_i=4'b0010, ex_pc_i=0x40, imm_i=0xFFFFFFF0 → next cycle:
  - pc_o=0x30, redirect_o=1.
  - flush_o high exactly 2 cycles.
  - Simultaneous if_ready_i does not add 4.
- jalr with rs1_i=0x1001, imm_i=0x2 and feature off → pc_o=0x1000.
  - Same jal with target 0x102 and feature on → pc_o=0x100 (TRAP_VEC), misalign_o=1.
- branch_type_i=4'b1110 (jalr+jal+btype) → jalr target selected.
  - branch_type_i=4'b0001 → no redirect, pc increments.
- Second taken branch during FLUSH → ignored.
  - stall_i=1 with taken branch → no redirect, pc_o holds.
- rst_n low during the FLUSH cycle 1 → next cycle:
  - pc_o=RESET_PC, flush_o=0, state IDLE.
